// File: rtl/booth_pkg.sv
// Shared types, defaults and the round-robin pick helper for the Booth
// multiplier arbiter.
package booth_pkg;

    localparam int NREQ_DEF = 4;
    localparam int W_DEF    = 4;

    // The pick helper works on a fixed 8-wide request vector so it can serve
    // every legal NREQ; unused upper bits are tied low by the caller.
    localparam int MAX_NREQ = 8;
    localparam int RR_PTR_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } booth_state_e;

    // First set bit at or after ptr, searching upward with wrap. Because the
    // bits at and above NREQ are always zero, wrapping modulo 8 gives the
    // same winner as wrapping at NREQ-1.
    function automatic logic [RR_PTR_W-1:0] rr_pick(
        input logic [MAX_NREQ-1:0] valid,
        input logic [RR_PTR_W-1:0] ptr
    );
        logic [RR_PTR_W-1:0] idx;
        rr_pick = ptr;
        for (int k = MAX_NREQ - 1; k >= 0; k--) begin
            idx = ptr + RR_PTR_W'(k);
            if (valid[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/booth_seq_core.sv
// Sequential radix-2 Booth multiplier: one iteration per clock, W iterations
// per product. The accumulator is W+1 bits so -2^(W-1) never overflows.
module booth_seq_core
    import booth_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic [W-1:0]   m,
    input  logic [W-1:0]   q,
    output logic           done,
    output logic [2*W-1:0] p
);

    localparam int CW = $clog2(W + 1);

    logic [W:0]    r_a;
    logic [W:0]    r_m;
    logic [W-1:0]  r_q;
    logic          r_q_m1;
    logic [CW-1:0] r_count;
    logic          r_run;
    logic [W:0]    w_sum;

    // Booth add/subtract selected by the pair {q[0], q_-1}.
    always_comb begin
        w_sum = r_a;
        case ({r_q[0], r_q_m1})
            2'b10:   w_sum = r_a - r_m;
            2'b01:   w_sum = r_a + r_m;
            default: w_sum = r_a;
        endcase
    end

    // done flags the final iteration; p is {A,q} after that iteration's
    // arithmetic shift, so the caller can register it on the same edge.
    assign done = r_run && (r_count == CW'(1));
    assign p    = {w_sum, r_q[W-1:1]};

    // Load operands on start, otherwise add then shift {A,q,q_-1} right.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a     <= '0;
            r_m     <= '0;
            r_q     <= '0;
            r_q_m1  <= 1'b0;
            r_count <= '0;
            r_run   <= 1'b0;
        end else if (start) begin
            r_a     <= '0;
            r_m     <= {m[W-1], m};
            r_q     <= q;
            r_q_m1  <= 1'b0;
            r_count <= CW'(W);
            r_run   <= 1'b1;
        end else if (r_run) begin
            r_a     <= {w_sum[W], w_sum[W:1]};
            r_q     <= {w_sum[0], r_q[W-1:1]};
            r_q_m1  <= r_q[0];
            r_count <= r_count - CW'(1);
            if (r_count == CW'(1)) begin
                r_run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter and sequencer sharing one Booth multiplier core among
// NREQ requesters; returns the product and owner ID over a valid/ready port.
module booth_mul_arbiter
    import booth_pkg::*;
#(
    parameter  int NREQ = NREQ_DEF,
    parameter  int W    = W_DEF,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_m,
    input  logic [NREQ*W-1:0] req_q,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [2*W-1:0]    rsp_p,
    output logic              busy
);

    booth_state_e          r_state;
    booth_state_e          w_state_next;
    logic [IDW-1:0]        r_rr_ptr;
    logic [IDW-1:0]        r_rsp_id;
    logic [2*W-1:0]        r_rsp_p;
    logic [MAX_NREQ-1:0]   w_valid_ext;
    logic [IDW-1:0]        w_pick;
    logic [W-1:0]          w_sel_m;
    logic [W-1:0]          w_sel_q;
    logic                  w_start;
    logic                  w_core_done;
    logic [2*W-1:0]        w_core_p;

    // Widen the request vector to the helper's fixed width and steer the
    // winner's operands toward the core.
    always_comb begin
        w_valid_ext              = '0;
        w_valid_ext[NREQ-1:0]    = req_valid;
        w_pick                   = IDW'(rr_pick(w_valid_ext, RR_PTR_W'(r_rr_ptr)));
        w_sel_m                  = req_m[int'(w_pick)*W +: W];
        w_sel_q                  = req_q[int'(w_pick)*W +: W];
    end

    // Next state and grant. The grant is masked while reset is held so that
    // a requester sitting on req_valid is not shown a ready it cannot get.
    always_comb begin
        w_state_next = r_state;
        req_ready    = '0;
        w_start      = 1'b0;
        case (r_state)
            IDLE: begin
                if (reset_n && (|req_valid)) begin
                    req_ready[w_pick] = 1'b1;
                    w_start           = 1'b1;
                    w_state_next      = RUN;
                end
            end
            RUN: begin
                if (w_core_done) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Response registers and round-robin pointer; the pointer moves past the
    // served requester only once its response has been taken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_id <= '0;
            r_rsp_p  <= '0;
            r_rr_ptr <= '0;
        end else begin
            if (w_start) begin
                r_rsp_id <= w_pick;
            end
            if ((r_state == RUN) && w_core_done) begin
                r_rsp_p <= w_core_p;
            end
            if ((r_state == DONE) && rsp_ready) begin
                r_rr_ptr <= (r_rsp_id == IDW'(NREQ - 1)) ? '0 : r_rsp_id + IDW'(1);
            end
        end
    end

    booth_seq_core #(
        .W (W)
    ) u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (w_start),
        .m       (w_sel_m),
        .q       (w_sel_q),
        .done    (w_core_done),
        .p       (w_core_p)
    );

    assign rsp_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign rsp_id    = r_rsp_id;
    assign rsp_p     = r_rsp_p;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Bench for booth_mul_arbiter: table of directed products, hand-written
// round-robin / stall / reset sequences, then random traffic on all
// requesters against a scoreboard and a cycle-level reference model.
module tb_booth_mul_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int IDW  = 2;
    localparam int PW   = 2 * W;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_m;
    logic [NREQ*W-1:0] req_q;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [IDW-1:0]    rsp_id;
    logic [PW-1:0]     rsp_p;
    logic              busy;

    always #5 clk = ~clk;

    booth_mul_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_m     (req_m),
        .req_q     (req_q),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p),
        .busy      (busy)
    );

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [PW-1:0]  p;
    } exp_t;

    typedef struct {
        int           id;
        logic [W-1:0] m;
        logic [W-1:0] q;
        logic [PW-1:0] p;
    } vec_t;

    // Requester-side state: pending flag and operands per requester.
    logic [NREQ-1:0] pend = '0;
    logic [W-1:0]    pm [NREQ];
    logic [W-1:0]    pq [NREQ];
    logic [PW-1:0]   pe [NREQ];

    always_comb begin
        req_valid = pend;
        req_m     = '0;
        req_q     = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_m[i*W +: W] = pm[i];
            req_q[i*W +: W] = pq[i];
        end
    end

    exp_t sb[$];
    int   glog[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   ms = 0;        // model state: 0 idle, 1 run, 2 done
    int   mcnt = 0;
    int   mptr = 0;
    int   mid = 0;
    int   waits[NREQ];
    int   ngrant = 0;
    int   rdy_mode = 0;  // 0 always ready, 1 random, 2 held low
    bit   gen_en = 1'b0;
    bit   rearm = 1'b0;
    vec_t vecs[8];

    function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        int pa;
        int pb;
        pa = int'($signed(a));
        pb = int'($signed(b));
        return PW'(pa * pb);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive at the falling edge, compare against the model, then
    // advance the model across the rising edge.
    task automatic step();
        int            g;
        logic [NREQ-1:0] er;
        logic          rdy_now;
        if (gen_en) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
                    pm[i]   = W'($urandom);
                    pq[i]   = W'($urandom);
                    pe[i]   = ref_mul(pm[i], pq[i]);
                    pend[i] = 1'b1;
                end
            end
        end
        case (rdy_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'($urandom_range(0, 1));
            default: rsp_ready = 1'b0;
        endcase
        #1;
        er = '0;
        g  = -1;
        if (ms == 0) begin
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = (mptr + k) % NREQ;
                if (g < 0 && pend[idx]) g = idx;
            end
            if (g >= 0) er[g] = 1'b1;
        end
        check("req_ready", 32'(req_ready), 32'(er));
        check("busy", 32'(busy), 32'(ms != 0));
        check("rsp_valid", 32'(rsp_valid), 32'(ms == 2));
        if (ms == 2) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rsp_spurious: got id %0d p %0h expected no response", rsp_id, rsp_p);
            end else begin
                check("rsp_id", 32'(rsp_id), 32'(sb[0].id));
                check("rsp_p", 32'(rsp_p), 32'(sb[0].p));
            end
        end
        rdy_now = rsp_ready;
        @(posedge clk);
        #1;
        if (ms == 0 && g >= 0) begin
            for (int i = 0; i < NREQ; i++) begin
                if (pend[i] && i != g) waits[i]++;
            end
            check("wait_bound", 32'(waits[g] <= NREQ - 1), 32'd1);
            waits[g] = 0;
            sb.push_back('{id: IDW'(g), p: pe[g]});
            glog.push_back(g);
            ngrant++;
            pend[g] = rearm;
            ms   = 1;
            mcnt = W;
            mid  = g;
        end else if (ms == 1) begin
            mcnt--;
            if (mcnt == 0) ms = 2;
        end else if (ms == 2 && rdy_now) begin
            void'(sb.pop_front());
            mptr = (mid + 1) % NREQ;
            ms   = 0;
        end
        @(negedge clk);
    endtask

    task automatic run_until_idle(input string name, input int limit);
        int c;
        c = 0;
        while (!(ms == 0 && pend == '0 && sb.size() == 0) && c < limit) begin
            step();
            c++;
        end
        check(name, 32'(c < limit), 32'd1);
    endtask

    task automatic run_until_state(input string name, input int st, input int limit);
        int c;
        c = 0;
        while (ms != st && c < limit) begin
            step();
            c++;
        end
        check(name, 32'(c < limit), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            pm[i] = '0; pq[i] = '0; pe[i] = '0; waits[i] = 0;
        end
        vecs[0] = '{id: 0, m: 4'h3, q: 4'hE, p: 8'hFA};
        vecs[1] = '{id: 1, m: 4'h8, q: 4'h8, p: 8'h40};
        vecs[2] = '{id: 2, m: 4'h8, q: 4'h7, p: 8'hC8};
        vecs[3] = '{id: 3, m: 4'h7, q: 4'h7, p: 8'h31};
        vecs[4] = '{id: 0, m: 4'h0, q: 4'h8, p: 8'h00};
        vecs[5] = '{id: 1, m: 4'hF, q: 4'hF, p: 8'h01};
        vecs[6] = '{id: 2, m: 4'h8, q: 4'h1, p: 8'hF8};
        vecs[7] = '{id: 3, m: 4'h5, q: 4'hD, p: 8'hF1};

        // Reset state, with a request already waiting to prove ready is masked.
        pend[0] = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_p", 32'(rsp_p), 32'd0);
        pend[0] = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed products, one requester at a time.
        for (int v = 0; v < 8; v++) begin
            pm[vecs[v].id]   = vecs[v].m;
            pq[vecs[v].id]   = vecs[v].q;
            pe[vecs[v].id]   = vecs[v].p;
            pend[vecs[v].id] = 1'b1;
            run_until_idle("vec_timeout", 40);
            $display("vec %0d: id %0d m %0h q %0h expect %0h", v, vecs[v].id, vecs[v].m, vecs[v].q, vecs[v].p);
        end

        // Two requesters held high from rr_ptr=0: order must be 0, 2, 0.
        glog.delete();
        rearm = 1'b1;
        pm[0] = 4'h2; pq[0] = 4'h3; pe[0] = 8'h06; pend[0] = 1'b1;
        pm[2] = 4'hC; pq[2] = 4'h3; pe[2] = 8'hF4; pend[2] = 1'b1;
        begin
            int c;
            c = 0;
            while (glog.size() < 3 && c < 60) begin
                step();
                c++;
            end
            check("rr_timeout", 32'(c < 60), 32'd1);
        end
        rearm = 1'b0;
        pend  = '0;
        if (glog.size() >= 3) begin
            check("rr_order0", 32'(glog[0]), 32'd0);
            check("rr_order1", 32'(glog[1]), 32'd2);
            check("rr_order2", 32'(glog[2]), 32'd0);
        end
        run_until_idle("rr_drain", 40);
        $display("rr sequence: grants %0d %0d %0d", glog[0], glog[1], glog[2]);

        // Stall DONE for 10 cycles with other requests waiting.
        pm[1] = 4'h2; pq[1] = 4'h3; pe[1] = 8'h06; pend[1] = 1'b1;
        pm[3] = 4'hC; pq[3] = 4'hC; pe[3] = 8'h10; pend[3] = 1'b1;
        rdy_mode = 0;
        run_until_state("stall_reach", 2, 40);
        rdy_mode = 2;
        repeat (10) step();
        rdy_mode = 0;
        run_until_idle("stall_drain", 60);
        $display("stall sequence: done");

        // Reset during the second RUN cycle, then re-accept the same request.
        pm[1] = 4'hD; pq[1] = 4'h5; pe[1] = 8'hF1; pend[1] = 1'b1;
        run_until_state("rstrun_reach", 1, 40);
        step();
        reset_n = 1'b0;
        pend[1] = 1'b1;
        #1;
        check("rstrun_req_ready", 32'(req_ready), 32'd0);
        check("rstrun_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rstrun_busy", 32'(busy), 32'd0);
        check("rstrun_rsp_id", 32'(rsp_id), 32'd0);
        check("rstrun_rsp_p", 32'(rsp_p), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        ms = 0; mcnt = 0; mptr = 0;
        sb.delete();
        for (int i = 0; i < NREQ; i++) waits[i] = 0;
        run_until_idle("rstrun_drain", 40);
        $display("reset-in-run sequence: done");

        // Random traffic on all requesters with random rsp_ready.
        gen_en   = 1'b1;
        rdy_mode = 1;
        ngrant   = 0;
        begin
            int c;
            c = 0;
            while (ngrant < 2000 && c < 60000) begin
                step();
                c++;
            end
            check("rand_timeout", 32'(c < 60000), 32'd1);
        end
        gen_en = 1'b0;
        run_until_idle("rand_drain", 200);
        $display("random traffic: %0d grants", ngrant);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
